mpu_fault_queue: RTL and testbench

Captures memory-protection faults flagged by the MPU and queues them for the n-CLIC memory-exception handler. Each faulting load/store is recorded with its address, access kind and task id in a small FIFO. While the FIFO is non-empty, a level interrupt request is raised toward the n-CLIC; the handler drains the FIFO one entry at a time. A combinational kill strobe stops a faulting store from writing memory in the same cycle.

---
 rtl/mpu_fault_queue.sv | 103 ++++++++++
 tb/tb_mpu_fault_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mpu_fault_queue.sv
// Fault capture FIFO between the MPU and the n-CLIC memory-exception handler.
// Records {addr, is_store, id} per faulting load/store and raises a level IRQ while non-empty.
module mpu_fault_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_fault,
    input  logic                     mem_valid,
    input  logic [15:0]              addr,
    input  logic [6:0]               op,
    input  logic [3:0]               id,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     store_kill,
    output logic                     fault_irq,
    output logic [15:0]              head_addr,
    output logic                     head_is_store,
    output logic [3:0]               head_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [15:0] addr;
        logic        is_store;
        logic [3:0]  id;
    } fault_ent_t;

    fault_ent_t        mem [DEPTH];
    fault_ent_t        head;
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              overflow_nxt;
    logic              is_load, is_store, push, do_push, do_pop, full, empty;

    assign is_load    = (op == OP_LOAD);
    assign is_store   = (op == OP_STORE);
    assign push       = mem_valid & mem_fault & (is_load | is_store);
    // Kill must not wait on FIFO state: a dropped store still may not write memory.
    assign store_kill = mem_valid & mem_fault & is_store;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_push      = 1'b0;
        do_pop       = 1'b0;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        overflow_nxt = overflow;
        if (clear) begin
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            count_nxt    = '0;
            overflow_nxt = 1'b0;
        end else begin
            do_pop  = pop & ~empty;
            // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
            do_push = push & (~full | do_pop);
            if (push & full & ~do_pop)
                overflow_nxt = 1'b1;
            if (do_push)
                wr_ptr_nxt = wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr_nxt = rd_ptr + 1'b1;
            count_nxt = count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            fault_irq <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            fault_irq <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= '{addr: addr, is_store: is_store, id: id};
    end

    assign head          = empty ? '0 : mem[rd_ptr];
    assign head_addr     = head.addr;
    assign head_is_store = head.is_store;
    assign head_id       = head.id;

endmodule

// File: tb/tb_mpu_fault_queue.sv
// Scoreboard bench for mpu_fault_queue: a queue model tracks expected entries and overflow.
module tb_mpu_fault_queue;

    localparam int DEPTH = 4;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_fault = 1'b0, mem_valid = 1'b0, pop = 1'b0, clear = 1'b0;
    logic [15:0] addr = '0;
    logic [6:0]  op = '0;
    logic [3:0]  id = '0;
    logic        store_kill, fault_irq, head_is_store, overflow;
    logic [15:0] head_addr;
    logic [3:0]  head_id;
    logic [2:0]  count;

    mpu_fault_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_fault(mem_fault), .mem_valid(mem_valid),
        .addr(addr), .op(op), .id(id), .pop(pop), .clear(clear),
        .store_kill(store_kill), .fault_irq(fault_irq), .head_addr(head_addr),
        .head_is_store(head_is_store), .head_id(head_id), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic        s;
        logic [3:0]  i;
    } ent_t;

    ent_t sb[$];
    logic m_ovf = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        ent_t h;
        h = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, ":count"},     32'(count),         32'(sb.size()));
        chk({tag, ":irq"},       32'(fault_irq),     32'(sb.size() != 0));
        chk({tag, ":head_addr"}, 32'(head_addr),     32'(h.a));
        chk({tag, ":head_st"},   32'(head_is_store), 32'(h.s));
        chk({tag, ":head_id"},   32'(head_id),       32'(h.i));
        chk({tag, ":overflow"},  32'(overflow),      32'(m_ovf));
    endtask

    // Drive one cycle of stimulus, update the model, then check state after the edge.
    task automatic step(input string tag, input logic v, input logic f, input logic [15:0] a,
                        input logic [6:0] o, input logic [3:0] i, input logic p, input logic c);
        logic push, do_pop;
        ent_t e;
        mem_valid = v; mem_fault = f; addr = a; op = o; id = i; pop = p; clear = c;
        #1;
        chk({tag, ":store_kill"}, 32'(store_kill), 32'(v & f & (o == ST)));
        push = v & f & ((o == LD) | (o == ST));
        e = '{a: a, s: (o == ST), i: i};
        if (c) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop = p && (sb.size() != 0);
            if (do_pop) void'(sb.pop_front());
            if (push) begin
                if (sb.size() < DEPTH) sb.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 0; mem_fault = 0; pop = 0; clear = 0; addr = '0; op = '0; id = '0;
        check_state(tag);
    endtask

    task automatic fault(input string tag, input logic [15:0] a, input logic [6:0] o, input logic [3:0] i);
        step(tag, 1'b1, 1'b1, a, o, i, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input string tag);
        step(tag, 1'b0, 1'b0, 16'h0, 7'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 16'h0, 7'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check_state("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle("idle0");
        idle("idle1");

        // Single load fault
        fault("ld1234", 16'h1234, LD, 4'd3);
        chk("ld1234:addr_const", 32'(head_addr), 32'h1234);
        chk("ld1234:id_const",   32'(head_id),   32'd3);
        do_pop("pop_ld");

        // Store without fault, then store fault
        step("st_nofault", 1'b1, 1'b0, 16'h0200, ST, 4'd1, 1'b0, 1'b0);
        fault("st_fault", 16'h0200, ST, 4'd1);
        chk("st_fault:is_store_const", 32'(head_is_store), 32'd1);
        do_pop("pop_st");
        do_pop("pop_empty");

        // Fill and overflow
        for (int k = 1; k <= 5; k++) fault("fill", 16'(k * 16), LD, 4'(k));
        chk("fill:count_const", 32'(count),    32'd4);
        chk("fill:ovf_const",   32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) do_pop("drain");
        chk("drain:ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push+pop on full FIFO, wrapping pointers
        step("clr", 1'b0, 1'b0, 16'h0, 7'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) fault("refill", 16'(k * 16), LD, 4'(k));
        step("full_pushpop", 1'b1, 1'b1, 16'h0060, LD, 4'd6, 1'b1, 1'b0);
        chk("full_pushpop:count_const", 32'(count), 32'd4);
        for (int k = 0; k < 4; k++) do_pop("wrap_drain");
        step("empty_pushpop", 1'b1, 1'b1, 16'h0070, ST, 4'd7, 1'b1, 1'b0);
        chk("empty_pushpop:count_const", 32'(count), 32'd1);
        do_pop("pop_last");

        // Clear beats push and pop
        fault("q1", 16'h0A00, LD, 4'd2);
        fault("q2", 16'h0B00, ST, 4'd4);
        step("clr_pushpop", 1'b1, 1'b1, 16'h0C00, LD, 4'd5, 1'b1, 1'b1);

        // Ignored inputs
        step("alu_fault", 1'b1, 1'b1, 16'h0D00, ALU, 4'd8, 1'b0, 1'b0);
        step("novalid_ld", 1'b0, 1'b1, 16'h0E00, LD, 4'd9, 1'b0, 1'b0);
        step("novalid_st", 1'b0, 1'b1, 16'h0F00, ST, 4'd9, 1'b0, 1'b0);

        // Async reset between edges with 3 entries queued
        fault("pre_rst", 16'h1111, LD, 4'd1);
        fault("pre_rst", 16'h2222, ST, 4'd2);
        fault("pre_rst", 16'h3333, LD, 4'd3);
        #1;
        reset = 1'b0;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        fault("post_rst", 16'h4444, ST, 4'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
